alu_seq_flags: RTL and testbench
================================

Name: alu_seq_flags

Overview:
Parametrised, registered successor to the team's 16-bit combinational flag ALU. It adds valid/ready handshakes on input and output, and a multi-cycle iterative multiplier. All flags (Sign, Zero, Parity, Carry, Overflow) are defined for every op, with no don't-care values. The block sits between the operand-issue logic and the writeback/flag-consumer stage of the datapath.

Parameters:
- WIDTH, 16: operand/result width in bits; must be ≥ 4 and a power of 2.
- SHW, $clog2(WIDTH): shift-amount width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operands and op valid.
- in_ready  out  1  block can accept this cycle.
- Op  in  3  000 ADD, 001 SUB, 010 SHL, 011 SHR, 100 OR, 101 AND, 110 XOR, 111 MUL.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- Out  out  WIDTH  result.
- Sign, Zero, Parity, Carry, Overflow  out  1 each  flags registered with Out.
- ovf_clr  in  1  only with ALU_STICKY_OVF_EN: clears the sticky flag.
- ovf_sticky  out  1  only with ALU_STICKY_OVF_EN: accumulated overflow.

Behaviour:
- Clocking and reset: single clock domain. rst is synchronous, active-high, and overrides all other inputs.
- Reset values: state=IDLE, out_valid=0, Out=0, all flags=0, iteration counter=0, ovf_sticky=0.
- Transfers: input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
- in_ready: equals (state==IDLE) & (!out_valid | out_ready). Combinational from state and out_ready only, never from in_valid.
- One result register, no queue. A transfer in the same cycle as an output transfer is legal (full throughput for single-cycle ops).
- While out_valid=1 and out_ready=0, Out and all flags hold stable.
- FSM IDLE, non-MUL op accepted: result and flags registered at the next edge. out_valid=1 one cycle after accept (latency 1). State stays IDLE.
- FSM IDLE, MUL accepted: latch A and B, clear the accumulator, counter=0, go to BUSY.
- FSM BUSY: in_ready=0. One shift-add iteration per cycle using the LSB of the multiplier. The counter increments each cycle.
- BUSY exit: on the iteration with counter==WIDTH-1, load the low WIDTH product bits into Out with flags, set out_valid=1, and return to IDLE. MUL latency = WIDTH cycles from accept edge to out_valid.
- ADD: {Carry,Out} = A+B at WIDTH+1 bits. Overflow = signed overflow (operand signs equal and result sign differs).
- SUB: Out = A-B. Carry = borrow (1 iff A<B unsigned). Overflow = signed overflow (operand signs differ and result sign ≠ A sign).
- SHL/SHR: logical shift; amount = B[SHW-1:0], upper B bits ignored. Carry = last bit shifted out, 0 if amount=0. Overflow=0.
- OR/AND/XOR: bitwise. Carry=0, Overflow=0.
- MUL: unsigned. Out = product[WIDTH-1:0]. Overflow=1 iff product[2*WIDTH-1:WIDTH]≠0. Carry=0.
- Flags for all ops: Sign=Out[WIDTH-1]; Zero=(Out==0); Parity=~^Out (1 for an even number of ones).
- Op outside the table: none exist; all 8 codes are defined.
- rst while BUSY: abandon the multiply, no result is produced, and the block is back in IDLE with in_ready=1 next cycle.
- in_valid while in_ready=0: ignored; the driver must hold it until in_ready is high.

Optional Feature:
ALU_STICKY_OVF_EN.
- Defined: adds ports ovf_clr and ovf_sticky. ovf_sticky sets on any output transfer with Overflow=1 and clears on ovf_clr or rst. If set and clear coincide, set wins.
- Undefined: neither port exists and there is no extra logic.

Test Plan:
- ADD A=0x7FFF, B=0x0001 → next cycle out_valid=1, Out=0x8000, Sign=1, Overflow=1, Carry=0, Zero=0, Parity=0.
- SUB A=0x0003, B=0x0005 → Out=0xFFFE, Carry=1, Sign=1, Overflow=0, Parity=0. Then SUB A=0x1234, B=0x1234 → Out=0, Zero=1, Parity=1.
- MUL A=0x0100, B=0x0100 (WIDTH=16) → in_ready=0 for 16 cycles, out_valid exactly 16 cycles after accept, Out=0x0000, Zero=1, Overflow=1. Then MUL 0x00FF×0x0003 → Out=0x02FD, Overflow=0.
- SHL A=0x8001, B=0x0011 → amount 1, Out=0x0002, Carry=1. SHR A=0x0001, B=0x0000 → Out=0x0001, Carry=0.
- Backpressure: out_ready=0, ADD 1+2 accepted → Out=0x0003 held for 5 cycles, in_ready=0 throughout. Raise out_ready with XOR 0xFF00^0x0FF0 pending → same-cycle transfer, next Out=0xF0F0.
- rst asserted for 1 cycle on the 5th cycle of BUSY → next cycle state=IDLE, out_valid=0, in_ready=1, all flags 0. With ALU_STICKY_OVF_EN: 0x7FFF+1 consumed → ovf_sticky=1; ovf_clr pulse → 0.

Source files
------------

// File: rtl/alu_seq_flags.sv
// alu_seq_flags: registered flag ALU with valid/ready handshakes and an iterative shift-add multiplier; optional sticky overflow via ALU_STICKY_OVF_EN.
module alu_seq_flags #(
  parameter int WIDTH = 16,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             Sign,
  output logic             Zero,
  output logic             Parity,
  output logic             Carry,
  output logic             Overflow
`ifdef ALU_STICKY_OVF_EN
  ,input logic             ovf_clr,
  output logic             ovf_sticky
`endif
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [0:0] state;
  logic [SHW-1:0] cnt;
  logic [2*WIDTH-1:0] ma, acc, prod;
  logic [WIDTH-1:0] mb, r;
  logic [SHW-1:0] sh;
  logic cy, ov;
  assign in_ready = (state == IDLE) & (!out_valid | out_ready);
  assign sh = B[SHW-1:0];
  assign prod = acc + (mb[0] ? ma : '0);
  // In BUSY the load path carries the final multiply iteration, otherwise the single-cycle op.
  always_comb begin
    r = '0;
    cy = 1'b0;
    ov = 1'b0;
    if (state == BUSY) begin
      r = prod[WIDTH-1:0];
      ov = |prod[2*WIDTH-1:WIDTH];
    end else begin
      case (Op)
        3'b000: begin
          {cy, r} = {1'b0, A} + {1'b0, B};
          ov = (A[WIDTH-1] == B[WIDTH-1]) && (r[WIDTH-1] != A[WIDTH-1]);
        end
        3'b001: begin
          {cy, r} = {1'b0, A} - {1'b0, B};
          ov = (A[WIDTH-1] != B[WIDTH-1]) && (r[WIDTH-1] != A[WIDTH-1]);
        end
        3'b010: {cy, r} = {1'b0, A} << sh;
        3'b011: {r, cy} = {A, 1'b0} >> sh;
        3'b100: r = A | B;
        3'b101: r = A & B;
        3'b110: r = A ^ B;
        default: r = '0;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out_valid <= 1'b0;
      Out <= '0;
      {Sign, Zero, Parity, Carry, Overflow} <= '0;
      cnt <= '0;
      ma <= '0;
      mb <= '0;
      acc <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (state == BUSY) begin
        acc <= prod;
        ma <= ma << 1;
        mb <= mb >> 1;
        cnt <= cnt + 1'b1;
        if (cnt == SHW'(WIDTH-1)) begin
          state <= IDLE;
          out_valid <= 1'b1;
          Out <= r;
          {Sign, Zero, Parity, Carry, Overflow} <= {r[WIDTH-1], ~|r, ~^r, cy, ov};
        end
      end else if (in_valid && in_ready) begin
        if (Op == 3'b111) begin
          state <= BUSY;
          ma <= {{WIDTH{1'b0}}, A};
          mb <= B;
          acc <= '0;
          cnt <= '0;
        end else begin
          out_valid <= 1'b1;
          Out <= r;
          {Sign, Zero, Parity, Carry, Overflow} <= {r[WIDTH-1], ~|r, ~^r, cy, ov};
        end
      end
    end
  end
`ifdef ALU_STICKY_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) ovf_sticky <= 1'b0;
    else if (out_valid && out_ready && Overflow) ovf_sticky <= 1'b1;
    else if (ovf_clr) ovf_sticky <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_alu_seq_flags.sv
// tb_alu_seq_flags: directed checks of alu_seq_flags (WIDTH=16); sticky overflow exercised when ALU_STICKY_OVF_EN is defined.
module tb_alu_seq_flags;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [2:0] Op = '0;
  logic [15:0] A = '0, B = '0, Out;
  logic Sign, Zero, Parity, Carry, Overflow;
  int checks = 0, errors = 0;
`ifdef ALU_STICKY_OVF_EN
  logic ovf_clr = 1'b0, ovf_sticky;
`endif
  alu_seq_flags dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .Op(Op), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready), .Out(Out), .Sign(Sign), .Zero(Zero),
    .Parity(Parity), .Carry(Carry), .Overflow(Overflow)
`ifdef ALU_STICKY_OVF_EN
    , .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky)
`endif
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1; Op = op; A = a; B = b;
    step();
    in_valid = 1'b0;
  endtask
  // flags packed as {Sign,Zero,Parity,Carry,Overflow}
  initial begin
    step(); step();
    rst = 1'b0;
    chk("reset_ctl", {out_valid, in_ready}, 2'b01);
    chk("reset_out", Out, 16'h0);
    chk("reset_flags", {Sign, Zero, Parity, Carry, Overflow}, 5'b00000);
    issue(3'b000, 16'h7FFF, 16'h0001);
    chk("add_ovf_valid", out_valid, 1'b1);
    chk("add_ovf_out", Out, 16'h8000);
    chk("add_ovf_flags", {Sign, Zero, Parity, Carry, Overflow}, 5'b10001);
    issue(3'b000, 16'hFFFF, 16'h0001);
    chk("add_carry", {Out, Sign, Zero, Parity, Carry, Overflow}, {16'h0000, 5'b01110});
    issue(3'b001, 16'h0003, 16'h0005);
    chk("sub_borrow", {Out, Sign, Zero, Parity, Carry, Overflow}, {16'hFFFE, 5'b10010});
    issue(3'b001, 16'h1234, 16'h1234);
    chk("sub_zero", {Out, Sign, Zero, Parity, Carry, Overflow}, {16'h0000, 5'b01100});
    issue(3'b010, 16'h8001, 16'h0011);
    chk("shl", {Out, Sign, Zero, Parity, Carry, Overflow}, {16'h0002, 5'b00010});
    issue(3'b011, 16'h0001, 16'h0000);
    chk("shr_zero_amt", {Out, Sign, Zero, Parity, Carry, Overflow}, {16'h0001, 5'b00000});
    issue(3'b011, 16'h00F3, 16'h0002);
    chk("shr", {Out, Sign, Zero, Parity, Carry, Overflow}, {16'h003C, 5'b00110});
    issue(3'b100, 16'hA000, 16'h0005);
    chk("or", {Out, Sign, Zero, Parity, Carry, Overflow}, {16'hA005, 5'b10100});
    issue(3'b101, 16'hF0F0, 16'h3C3C);
    chk("and", {Out, Sign, Zero, Parity, Carry, Overflow}, {16'h3030, 5'b00100});
    step();
    chk("drained", out_valid, 1'b0);
    issue(3'b111, 16'h0100, 16'h0100);
    for (int i = 0; i < 16; i++) begin
      chk("mul_busy", {in_ready, out_valid}, 2'b00);
      step();
    end
    chk("mul_done_valid", out_valid, 1'b1);
    chk("mul_ovf", {Out, Sign, Zero, Parity, Carry, Overflow}, {16'h0000, 5'b01101});
    issue(3'b111, 16'h00FF, 16'h0003);
    repeat (15) step();
    chk("mul_not_early", out_valid, 1'b0);
    step();
    chk("mul_small", {out_valid, Out, Sign, Zero, Parity, Carry, Overflow}, {1'b1, 16'h02FD, 5'b00100});
    step();
    out_ready = 1'b0;
    issue(3'b000, 16'h0001, 16'h0002);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {out_valid, in_ready, Out, Sign, Zero, Parity, Carry, Overflow}, {2'b10, 16'h0003, 5'b00100});
      step();
    end
    in_valid = 1'b1; Op = 3'b110; A = 16'hFF00; B = 16'h0FF0; out_ready = 1'b1;
    #1;
    chk("bp_ready_rise", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("xor_same_cycle", {out_valid, Out, Sign, Zero, Parity, Carry, Overflow}, {1'b1, 16'hF0F0, 5'b10100});
    step();
    issue(3'b111, 16'h0003, 16'h0003);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_busy_ctl", {out_valid, in_ready}, 2'b01);
    chk("rst_busy_out", {Out, Sign, Zero, Parity, Carry, Overflow}, 21'h0);
    repeat (20) step();
    chk("rst_busy_no_result", out_valid, 1'b0);
`ifdef ALU_STICKY_OVF_EN
    chk("sticky_reset", ovf_sticky, 1'b0);
    issue(3'b000, 16'h7FFF, 16'h0001);
    step();
    chk("sticky_set", ovf_sticky, 1'b1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("sticky_clr", ovf_sticky, 1'b0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
